// File: rtl/wb_seg_if.sv
// wb_seg_if: write-back stage bus bundle
// master drives the memory-stage inputs and register read addresses;
// slave (the write-back stage) returns read data, the pending write,
// the retired count and the advance strobe.
interface wb_seg_if;
    logic [31:0] ALUo_i;
    logic [31:0] LMD_i;
    logic [31:0] IR_i;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] retired;
    logic        advance;
    modport master (
        output ALUo_i, LMD_i, IR_i, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_we, wb_addr, wb_data, retired, advance
    );
    modport slave (
        input  ALUo_i, LMD_i, IR_i, rs_addr, rt_addr,
        output rs_data, rt_data, wb_we, wb_addr, wb_data, retired, advance
    );
endinterface

// File: rtl/wb_seg.sv
// wb_seg: multi-phase write-back stage with 32x32 register file
// clk, rst (async, active-high) plus bus (wb_seg_if.slave):
// latches ALUo/LMD/IR every PHASES cycles, decodes the pending write,
// commits it on the next advance and serves write-through register reads.
module wb_seg #(
    parameter int PHASES = 3
) (
    input logic      clk,
    input logic      rst,
    wb_seg_if.slave  bus
);
    localparam logic [3:0] LAST = 4'(PHASES - 1);
    logic [3:0]  ph;
    logic [31:0] aluo, lmd, ir, retired;
    logic [31:0] regs [32];
    logic [5:0]  op;
    logic        writes;
    logic [4:0]  dest;
    always_comb begin
        op     = ir[31:26];
        writes = op == 6'h00 || op[5:3] == 3'b001 || op == 6'h23;
        dest   = op == 6'h00 ? ir[15:11] : ir[20:16];
    end
    assign bus.advance = ph == LAST;
    assign bus.wb_we   = writes && dest != 5'd0;
    assign bus.wb_addr = dest;
    assign bus.wb_data = op == 6'h23 ? lmd : aluo;
    assign bus.retired = retired;
    // pending write bypasses the array so reads see it before commit
    assign bus.rs_data = bus.rs_addr == 5'd0 ? '0 :
                         (bus.wb_we && bus.rs_addr == bus.wb_addr) ? bus.wb_data : regs[bus.rs_addr];
    assign bus.rt_data = bus.rt_addr == 5'd0 ? '0 :
                         (bus.wb_we && bus.rt_addr == bus.wb_addr) ? bus.wb_data : regs[bus.rt_addr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph      <= '0;
            aluo    <= '0;
            lmd     <= '0;
            ir      <= '0;
            retired <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            ph <= bus.advance ? 4'd0 : ph + 4'd1;
            if (bus.advance) begin
                // commit the instruction latched before this edge, then capture the next
                if (bus.wb_we) regs[bus.wb_addr] <= bus.wb_data;
                if (ir != 32'd0) retired <= retired + 32'd1;
                aluo <= bus.ALUo_i;
                lmd  <= bus.LMD_i;
                ir   <= bus.IR_i;
            end
        end
    end
endmodule

// File: tb/tb_wb_seg.sv
// tb_wb_seg: directed and randomized checks of wb_seg against a behavioural model
module tb_wb_seg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    wb_seg_if b3();
    wb_seg_if b1();
    wb_seg #(.PHASES(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
    wb_seg #(.PHASES(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_ir, m_alu, m_lmd, m_ret;
    int m_cnt;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic void dec(input logic [31:0] ir, alu, lmd,
                                output logic we, output logic [4:0] a, output logic [31:0] d);
        int op;
        bit cls;
        op  = int'(ir[31:26]);
        cls = (op == 0) || (op >= 8 && op <= 15) || (op == 35);
        a   = (op == 0) ? ir[15:11] : ir[20:16];
        we  = cls && a != 0;
        d   = (op == 35) ? lmd : alu;
    endfunction
    function automatic logic [31:0] rd(input logic [4:0] ad);
        logic we;
        logic [4:0] a;
        logic [31:0] d;
        dec(m_ir, m_alu, m_lmd, we, a, d);
        if (ad == 0) return 0;
        if (we && ad == a) return d;
        return m_regs[ad];
    endfunction
    task automatic tick();
        logic we;
        logic [4:0] a;
        logic [31:0] d;
        @(posedge clk);
        if (m_cnt % 3 == 2) begin
            dec(m_ir, m_alu, m_lmd, we, a, d);
            if (we) m_regs[a] = d;
            if (m_ir != 0) m_ret = m_ret + 1;
            m_ir  = b3.IR_i;
            m_alu = b3.ALUo_i;
            m_lmd = b3.LMD_i;
        end
        m_cnt++;
        #1;
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    task automatic chk_model(input string tag);
        logic we;
        logic [4:0] a;
        logic [31:0] d;
        dec(m_ir, m_alu, m_lmd, we, a, d);
        chk({tag, ".adv"}, 32'(b3.advance), 32'(m_cnt % 3 == 2));
        chk({tag, ".we"}, 32'(b3.wb_we), 32'(we));
        if (we) begin
            chk({tag, ".addr"}, 32'(b3.wb_addr), 32'(a));
            chk({tag, ".data"}, b3.wb_data, d);
        end
        chk({tag, ".ret"}, b3.retired, m_ret);
        chk({tag, ".rs"}, b3.rs_data, rd(b3.rs_addr));
        chk({tag, ".rt"}, b3.rt_data, rd(b3.rt_addr));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_ir = 0; m_alu = 0; m_lmd = 0; m_ret = 0; m_cnt = 0;
        #2;
        chk("rst.we", 32'(b3.wb_we), 0);
        chk("rst.addr", 32'(b3.wb_addr), 0);
        chk("rst.data", b3.wb_data, 0);
        chk("rst.ret", b3.retired, 0);
        chk("rst.rs", b3.rs_data, 0);
        chk("rst.rt", b3.rt_data, 0);
        chk("rst.adv3", 32'(b3.advance), 0);
        chk("rst.adv1", 32'(b1.advance), 1);
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic set3(input logic [31:0] ir, alu, lmd);
        b3.IR_i = ir; b3.ALUo_i = alu; b3.LMD_i = lmd;
    endtask
    initial begin
        logic [31:0] r, ret0;
        logic [5:0] op;
        set3(0, 0, 0);
        b3.rs_addr = 0; b3.rt_addr = 0;
        b1.IR_i = 0; b1.ALUo_i = 0; b1.LMD_i = 0; b1.rs_addr = 8; b1.rt_addr = 9;
        #3;
        do_reset();
        // PHASES=1: new instruction every edge
        b1.IR_i = 32'h012A4020; b1.ALUo_i = 1;
        tick();
        chk("p1.adv", 32'(b1.advance), 1);
        chk("p1.we8", 32'(b1.wb_addr), 8);
        b1.IR_i = 32'h012A4820; b1.ALUo_i = 2;
        tick();
        b1.IR_i = 0;
        tick();
        chk("p1.r8", b1.rs_data, 1);
        chk("p1.r9", b1.rt_data, 2);
        chk("p1.ret", b1.retired, 2);
        // add r8
        do_reset();
        set3(32'h012A4020, 32'h55, 0);
        ticks(2);
        chk("add.adv", 32'(b3.advance), 1);
        tick();
        chk("add.we", 32'(b3.wb_we), 1);
        chk("add.addr", 32'(b3.wb_addr), 8);
        chk("add.data", b3.wb_data, 32'h55);
        ticks(3);
        b3.rs_addr = 8;
        #1;
        chk("add.r8", b3.rs_data, 32'h55);
        chk("add.ret", b3.retired, 1);
        chk_model("add");
        // write-through
        b3.ALUo_i = 32'h77;
        ticks(3);
        b3.rt_addr = 0;
        #1;
        chk("wt.rs", b3.rs_data, 32'h77);
        chk("wt.rt", b3.rt_data, 0);
        chk_model("wt");
        // lw
        set3(32'h8D090004, 32'h4, 32'hDEADBEEF);
        ticks(3);
        chk("lw.addr", 32'(b3.wb_addr), 9);
        chk("lw.data", b3.wb_data, 32'hDEADBEEF);
        set3(0, 0, 0);
        ticks(3);
        b3.rs_addr = 9;
        #1;
        chk("lw.r9", b3.rs_data, 32'hDEADBEEF);
        chk_model("lw");
        // sw and addi r0
        ret0 = b3.retired;
        set3(32'hAD090004, 32'h99, 32'h1);
        ticks(3);
        chk("sw.we", 32'(b3.wb_we), 0);
        set3(32'h20000007, 32'h99, 32'h1);
        ticks(3);
        chk("addi0.we", 32'(b3.wb_we), 0);
        chk("sw.ret", b3.retired, ret0 + 1);
        set3(0, 0, 0);
        ticks(3);
        chk("addi0.ret", b3.retired, ret0 + 2);
        chk("sw.r9", b3.rs_data, 32'hDEADBEEF);
        chk_model("sw");
        // reset mid-phase with pending write to r8
        set3(32'h012A4020, 32'h123, 0);
        ticks(3);
        tick();
        set3(0, 0, 0);
        do_reset();
        b3.rs_addr = 8;
        #1;
        chk("mid.r8", b3.rs_data, 0);
        chk("mid.ret", b3.retired, 0);
        chk("mid.we", 32'(b3.wb_we), 0);
        chk("mid.adv0", 32'(b3.advance), 0);
        tick();
        chk("mid.adv1", 32'(b3.advance), 0);
        tick();
        chk("mid.adv2", 32'(b3.advance), 1);
        // randomized: inputs change every cycle, including between advances
        for (int k = 0; k < 150; k++) begin
            r = $urandom;
            case ($urandom_range(0, 6))
                0: op = 6'h00;
                1: op = 6'(8 + $urandom_range(0, 7));
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'($urandom);
                default: op = 6'h00;
            endcase
            set3(k % 11 == 10 ? 32'd0 : {op, r[25:0]}, $urandom, $urandom);
            b3.rs_addr = 5'($urandom);
            b3.rt_addr = 5'($urandom);
            tick();
            chk_model("rnd");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_seg.md
WB_SEG -- requirements
Module: WBSeg

Interface
REQ-001 SHALL have parameter PHASES, default 3, meaning clock cycles per stage advance; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ALUo_i  input  32  ALU result from the memory stage.
REQ-005 SHALL have port LMD_i  input  32  load data from the memory stage.
REQ-006 SHALL have port IR_i  input  32  instruction from the memory stage.
REQ-007 SHALL have ports rs_addr, rt_addr  input  5 each  register-file read addresses.
REQ-008 SHALL have ports rs_data, rt_data  output  32 each  register-file read data.
REQ-009 SHALL have port wb_we  output  1  pending write of the latched instruction is enabled.
REQ-010 SHALL have port wb_addr  output  5  destination register of the latched instruction.
REQ-011 SHALL have port wb_data  output  32  write-back value of the latched instruction.
REQ-012 SHALL have port retired  output  32  count of committed non-zero instructions.
REQ-013 SHALL have port advance  output  1  high in the cycle whose rising edge commits and latches.

Function
REQ-014 SHALL keep phase counter ph, 0..PHASES-1, +1 per rising edge, wrapping PHASES-1 -> 0; advance = (ph == PHASES-1); PHASES=1 gives advance constantly 1.
REQ-015 SHALL, on a rising edge with advance=1, capture ALUo_i, LMD_i and IR_i into internal ALUo, LMD and IR; otherwise hold them.
REQ-016 SHALL decode the latched IR using opcode IR[31:26].
REQ-017 SHALL decode opcode 0x00 (R-type) as dest = IR[15:11], data = ALUo.
REQ-018 SHALL decode opcodes 0x08-0x0F (ALU immediate) as dest = IR[20:16], data = ALUo.
REQ-019 SHALL decode opcode 0x23 (lw) as dest = IR[20:16], data = LMD.
REQ-020 SHALL treat every other opcode, including sw 0x2B and branches, as no write.
REQ-021 SHALL drive wb_we = writing class AND dest != 0; wb_addr = dest; wb_data = selected data; all combinational from latched state.
REQ-022 SHALL contain a 32x32 register file; on a rising edge with advance=1 and wb_we=1, regs[wb_addr] <= wb_data, committed with the pre-edge latched instruction in the same edge that captures the next one.
REQ-023 SHALL return 0 for reads of register 0; register 0 is never written.
REQ-024 SHALL make reads combinational with write-through: if wb_we=1 and the read address equals wb_addr (non-zero), the read returns wb_data, else regs[addr].
REQ-025 SHALL increment retired (mod 2^32) on each rising edge with advance=1 where latched IR != 0, regardless of wb_we.
REQ-026 SHALL ignore input changes while advance=0; only the captured value matters.

Reset
REQ-027 SHALL, on rst=1, immediately clear ph, ALUo, LMD, IR, retired and all 32 registers to 0, independent of clk.
REQ-028 SHALL, while rst=1, hold wb_we=0, wb_addr=0, wb_data=0, retired=0, rs_data=rt_data=0; advance=1 only if PHASES=1.
REQ-029 SHALL, when reset asserts mid-phase, abandon any uncommitted write; first advance after release is PHASES rising edges later.

Verification
REQ-030 SHALL verify: PHASES=3, reset released, IR_i=0x012A4020 (add r8), ALUo_i=0x55 held; 3 edges -> wb_we=1, wb_addr=8, wb_data=0x55; 3 more edges -> read rs_addr=8 returns 0x55, retired=1.
REQ-031 SHALL verify: lw IR_i=0x8D090004 (rt=9), LMD_i=0xDEADBEEF, ALUo_i=0x4 -> wb_addr=9, wb_data=0xDEADBEEF; after commit, reg 9 = 0xDEADBEEF.
REQ-032 SHALL verify: sw IR_i=0xAD090004 and addi to r0 (0x20000007) -> wb_we=0, no register changes, retired +1 each.
REQ-033 SHALL verify write-through: latched add to r8 with ALUo=0x77, rs_addr=8 before commit -> rs_data=0x77; rt_addr=0 -> rt_data=0.
REQ-034 SHALL verify reset mid-operation: rst pulsed when ph=1 with pending write to r8 -> r8 reads 0, retired=0, wb_we=0, next advance exactly 3 edges after release.
REQ-035 SHALL verify PHASES=1: a new instruction every edge; back-to-back add r8=1 then add r9 commit both, retired=2.
